// File: rtl/armreduced_dmem_pkg.sv
// rtl/armreduced_dmem_pkg.sv - shared constants and types for the armreduced data memory
package armreduced_dmem_pkg;

    // MMIO register offsets, compared against memaddr[3:0]
    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_LOAD   = 4'h4;
    localparam logic [3:0] OFS_COUNT  = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    // CTRL register bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // load data returned for out-of-range RAM accesses
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/armreduced_dmem_timer.sv
// rtl/armreduced_dmem_timer.sv - memory-mapped down-counting timer with interrupt
// Ports: clk, reset (async, active high); wr = qualified MMIO write (be==4'b1111);
// ofs = register offset; wdata = store data; rdata = combinational register read;
// nIRQ = registered active-low interrupt, ~(PEND & IE).
module armreduced_dmem_timer
    import armreduced_dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [3:0]  ofs,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        nIRQ
);

    timer_state_t state_q, state_d;
    logic         en_q, en_d;
    logic         auto_q, auto_d;
    logic         ie_q, ie_d;
    logic         pend_q, pend_d;
    logic [31:0]  load_q, load_d;
    logic [31:0]  count_q, count_d;
    logic         terminal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            nIRQ    <= 1'b1;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
            count_q <= count_d;
            // built from next-state values so nIRQ falls on the edge that sets PEND
            nIRQ    <= ~(pend_d & ie_d);
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        pend_d   = pend_q;
        load_d   = load_q;
        count_d  = count_q;
        terminal = 1'b0;

        if (state_q == RUN) begin
            // <=1 rather than ==1: an auto-reload of LOAD=0 must not wrap to 2^32-1
            if (count_q <= 32'd1) begin
                terminal = 1'b1;
                pend_d   = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    count_d = 32'd0;
                    en_d    = 1'b0;
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        if (wr) begin
            case (ofs)
                OFS_CTRL: begin
                    auto_d = wdata[CTRL_AUTO];
                    ie_d   = wdata[CTRL_IE];
                    if (state_q == IDLE) begin
                        // starting with LOAD==0 is refused: EN self-clears
                        if (wdata[CTRL_EN] && (load_q != 32'd0)) begin
                            state_d = RUN;
                            en_d    = 1'b1;
                            count_d = load_q;
                        end else begin
                            en_d = 1'b0;
                        end
                    end else if (!wdata[CTRL_EN]) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        count_d = count_q;
                    end
                end
                OFS_LOAD:   load_d = wdata;
                OFS_STATUS: begin
                    // a terminal event in the same cycle keeps PEND set
                    if (wdata[0] && !terminal) begin
                        pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (ofs)
            OFS_CTRL:   rdata = {29'd0, ie_q, auto_q, en_q};
            OFS_LOAD:   rdata = load_q;
            OFS_COUNT:  rdata = count_q;
            OFS_STATUS: rdata = {31'd0, pend_q};
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/armreduced_dmem.sv
// rtl/armreduced_dmem.sv - data memory responder: word RAM plus MMIO timer for the armreduced core
// Ports: clk, reset (async, active high); memaddr/memwrite/memread/be/writedata = core request;
// readdata = registered load data (1-cycle latency, read-before-write); nIRQ = active-low timer IRQ;
// bus_err = sticky out-of-range flag, present only when ARMREDUCED_DMEM_BUS_ERR_EN is defined.
module armreduced_dmem
    import armreduced_dmem_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [15:0] MMIO_TAG = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        nIRQ
`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
    ,
    output logic        bus_err
`endif
);

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] ram_idx;
    logic              mmio_sel;
    logic              oor;
    logic              ram_wr;
    logic              mmio_wr;
    logic [31:0]       tmr_rdata;
    logic              unused_addr;

    assign mmio_sel = (memaddr[31:16] == MMIO_TAG);
    assign ram_idx  = memaddr[ADDR_W+1:2];

`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
    assign oor = ~mmio_sel & (|memaddr[31:ADDR_W+2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else if (oor && (memread || memwrite)) begin
            bus_err <= 1'b1;
        end
    end
`else
    // upper address bits alias onto the RAM
    assign oor = 1'b0;
`endif

    // word-offset bits and, depending on ADDR_W, some middle bits are don't-care
    assign unused_addr = ^memaddr;

    assign ram_wr  = memwrite & ~mmio_sel & ~oor;
    assign mmio_wr = memwrite & mmio_sel & (be == 4'b1111);

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // nonblocking RAM update makes a simultaneous read return the old word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= 32'd0;
        end else if (memread) begin
            if (mmio_sel) begin
                readdata <= tmr_rdata;
            end else if (oor) begin
                readdata <= DEADBEEF;
            end else begin
                readdata <= mem[ram_idx];
            end
        end
    end

    armreduced_dmem_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .wr    (mmio_wr),
        .ofs   (memaddr[3:0]),
        .wdata (writedata),
        .rdata (tmr_rdata),
        .nIRQ  (nIRQ)
    );

endmodule

// File: tb/tb_armreduced_dmem.sv
// tb/tb_armreduced_dmem.sv - self-checking bench for armreduced_dmem
module tb_armreduced_dmem;

    logic        clk;
    logic        reset;
    logic [31:0] memaddr;
    logic        memwrite;
    logic        memread;
    logic [3:0]  be;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        nIRQ;
`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
    logic        bus_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    armreduced_dmem #(.ADDR_W(10), .MMIO_TAG(16'hFFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .memaddr   (memaddr),
        .memwrite  (memwrite),
        .memread   (memread),
        .be        (be),
        .writedata (writedata),
        .readdata  (readdata),
        .nIRQ      (nIRQ)
`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
        ,
        .bus_err   (bus_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        rd;
        logic [3:0]  b;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam logic [31:0] CTRL   = 32'hFFFF_0000;
    localparam logic [31:0] LOAD   = 32'hFFFF_0004;
    localparam logic [31:0] COUNT  = 32'hFFFF_0008;
    localparam logic [31:0] STATUS = 32'hFFFF_000C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // apply one request for one rising edge, return 1 time unit after it
    task automatic drive(input logic [31:0] a, input logic w, input logic r,
                         input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        memaddr   = a;
        memwrite  = w;
        memread   = r;
        be        = b;
        writedata = d;
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [31:0] model [0:15];
    logic [31:0] exp_rd;
    logic [31:0] a, d, hi;
    logic [3:0]  b;
    logic        w, r;
    int          idx;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; memaddr = '0; memwrite = 1'b0; memread = 1'b0; be = '0; writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_nirq", {31'd0, nIRQ}, 32'd1);
`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
        check("reset_bus_err", {31'd0, bus_err}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // table-driven basic RAM and MMIO register behaviour
        vecs.push_back('{32'h10, 1'b1, 1'b0, 4'hF, 32'h1122_3344, 1'b0, 32'h0});
        vecs.push_back('{32'h10, 1'b1, 1'b0, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0});
        vecs.push_back('{32'h10, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h11BB_33DD});
        vecs.push_back('{32'h20, 1'b1, 1'b0, 4'hF, 32'h5,         1'b0, 32'h0});
        vecs.push_back('{32'h20, 1'b1, 1'b1, 4'hF, 32'h9,         1'b1, 32'h5});
        vecs.push_back('{32'h20, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h9});
        vecs.push_back('{32'h10, 1'b0, 1'b0, 4'hF, 32'h0,         1'b1, 32'h9});
        vecs.push_back('{CTRL,   1'b1, 1'b0, 4'hF, 32'h1,         1'b0, 32'h0});
        vecs.push_back('{CTRL,   1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{LOAD,   1'b1, 1'b0, 4'h3, 32'h1234,      1'b0, 32'h0});
        vecs.push_back('{32'h20, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h9});
        vecs.push_back('{LOAD,   1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{LOAD,   1'b1, 1'b0, 4'hF, 32'h1234,      1'b0, 32'h0});
        vecs.push_back('{LOAD,   1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h1234});
        vecs.push_back('{COUNT,  1'b1, 1'b0, 4'hF, 32'h77,        1'b0, 32'h0});
        vecs.push_back('{COUNT,  1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{LOAD,   1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h1234});
        vecs.push_back('{32'hFFFF_0006, 1'b0, 1'b1, 4'hF, 32'h0,  1'b1, 32'h0});
        vecs.push_back('{STATUS, 1'b0, 1'b1, 4'hF, 32'h0,         1'b1, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].b, vecs[i].wd);
            if (vecs[i].chk) check($sformatf("vec%0d", i), readdata, vecs[i].exp);
        end

`ifndef ARMREDUCED_DMEM_BUS_ERR_EN
        // upper address bits alias onto the same RAM word
        drive(32'h0000_1010, 1'b1, 1'b0, 4'hF, 32'h0000_0055);
        drive(32'h0000_0010, 1'b0, 1'b1, 4'hF, 32'h0);
        check("alias_read", readdata, 32'h0000_0055);
`endif

        // randomized RAM traffic against an array model of a 16-word window at byte 0x100
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            drive(32'h100 + 32'(i * 4), 1'b1, 1'b0, 4'hF, model[i]);
        end
        drive(32'h100, 1'b0, 1'b1, 4'h0, 32'h0);
        exp_rd = model[0];
        check("rand_first", readdata, exp_rd);
        for (int n = 0; n < 300; n++) begin
            idx = int'($urandom_range(0, 15));
`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
            hi = 32'h0;
`else
            hi = $urandom & 32'h7FFF_F000;
`endif
            a = hi | (32'h100 + 32'(idx * 4)) | 32'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            if (r) exp_rd = model[idx];
            if (w) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) model[idx][8*k +: 8] = d[8*k +: 8];
                end
            end
            drive(a, w, r, b, d);
            check($sformatf("rand%0d", n), readdata, exp_rd);
        end

        // one-shot timer: LOAD=3, EN|IE
        drive(LOAD, 1'b1, 1'b0, 4'hF, 32'd3);
        drive(CTRL, 1'b1, 1'b0, 4'hF, 32'h5);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_count3", readdata, 32'd3);
        check("os_nirq_hi", {31'd0, nIRQ}, 32'd1);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_count2", readdata, 32'd2);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_count1", readdata, 32'd1);
        check("os_nirq_lo", {31'd0, nIRQ}, 32'd0);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_count0", readdata, 32'd0);
        drive(CTRL, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_ctrl_en_clr", readdata, 32'h4);
        drive(STATUS, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_pend", readdata, 32'h1);
        drive(STATUS, 1'b1, 1'b0, 4'hF, 32'h1);
        check("os_clr_nirq", {31'd0, nIRQ}, 32'd1);
        drive(STATUS, 1'b0, 1'b1, 4'hF, 32'h0);
        check("os_pend_clr", readdata, 32'h0);

        // auto-reload timer: LOAD=2, EN|AUTO|IE
        drive(LOAD, 1'b1, 1'b0, 4'hF, 32'd2);
        drive(CTRL, 1'b1, 1'b0, 4'hF, 32'h7);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("ar_count_a", readdata, 32'd2);
        check("ar_nirq_a", {31'd0, nIRQ}, 32'd1);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("ar_count_b", readdata, 32'd1);
        check("ar_nirq_b", {31'd0, nIRQ}, 32'd0);
        drive(STATUS, 1'b1, 1'b0, 4'hF, 32'h1);
        check("ar_clr", {31'd0, nIRQ}, 32'd1);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("ar_count_c", readdata, 32'd1);
        check("ar_nirq_c", {31'd0, nIRQ}, 32'd0);
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("ar_reload", readdata, 32'd2);
        drive(STATUS, 1'b1, 1'b0, 4'hF, 32'h1);
        check("ar_set_wins_nirq", {31'd0, nIRQ}, 32'd0);
        drive(STATUS, 1'b0, 1'b1, 4'hF, 32'h0);
        check("ar_set_wins_pend", readdata, 32'h1);

        // asynchronous reset while running with nIRQ low
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_nirq", {31'd0, nIRQ}, 32'd1);
        check("arst_readdata", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(COUNT, 1'b0, 1'b1, 4'hF, 32'h0);
        check("arst_count", readdata, 32'd0);
        drive(LOAD, 1'b0, 1'b1, 4'hF, 32'h0);
        check("arst_load", readdata, 32'd0);
        drive(32'h20, 1'b0, 1'b1, 4'hF, 32'h0);
        check("arst_ram_kept", readdata, 32'h9);
        drive(CTRL, 1'b0, 1'b1, 4'hF, 32'h0);
        check("arst_ctrl", readdata, 32'd0);

`ifdef ARMREDUCED_DMEM_BUS_ERR_EN
        drive(32'h0000_0000, 1'b1, 1'b0, 4'hF, 32'hCAFE_0000);
        check("be_before", {31'd0, bus_err}, 32'd0);
        drive(32'h0000_1000, 1'b1, 1'b0, 4'hF, 32'h1234_5678);
        check("be_set", {31'd0, bus_err}, 32'd1);
        drive(32'h0000_1000, 1'b0, 1'b1, 4'hF, 32'h0);
        check("be_deadbeef", readdata, 32'hDEAD_BEEF);
        drive(32'h0000_0000, 1'b0, 1'b1, 4'hF, 32'h0);
        check("be_ram_intact", readdata, 32'hCAFE_0000);
        check("be_sticky", {31'd0, bus_err}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("be_reset", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
